// File: rtl/ring_osc_monitor_if.sv
// Control and result bus of the ring oscillator monitor.
// The controlling block uses master; the monitor uses slave.
interface ring_osc_monitor_if #(
  parameter int CNT_W = 9
);
  logic             start;
  logic             abort;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] edge_cnt;
  logic             stuck;
  logic             ovf;

  modport master (
    output start, abort,
    input  busy, valid, edge_cnt, stuck, ovf
  );

  modport slave (
    input  start, abort,
    output busy, valid, edge_cnt, stuck, ovf
  );
endinterface

// File: rtl/ring_osc_monitor.sv
// Ring oscillator enable sequencer and edge-count frequency meter.
// Optional idle-state stuck-high check: define RO_MON_IDLE_CHECK_EN.
module ring_osc_monitor #(
  parameter int WINDOW    = 256,
  parameter int SETTLE    = 16,
  parameter int CNT_W     = 9,
  parameter int MIN_EDGES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_osc_in,
  output logic              o_osc_en,
  output logic              o_idle_err,
  ring_osc_monitor_if.slave bus
);

  localparam int               MAXP      = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int               TMR_W     = $clog2(MAXP);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   MIN_CMP   = (CNT_W + 1)'(MIN_EDGES);

  // state     | meaning
  // S_IDLE    | oscillator off, waiting for start
  // S_SETTLE  | oscillator on, waiting for it to stabilise
  // S_MEASURE | counting synchronized rising edges over the window
  // S_REPORT  | oscillator off, results latched, valid pulsed
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_REPORT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ovf_acc;
  logic             w_ovf_acc_nxt;
  logic             w_report;
  logic             w_start_acc;
  logic             w_rise;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic             r_osc_en;
  logic             r_valid;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_stuck;
  logic             r_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_osc_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise      = r_sync2 & ~r_sync3;
  assign w_start_acc = (r_state == S_IDLE) && bus.start;

  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr;
    w_cnt_nxt     = r_cnt;
    w_ovf_acc_nxt = r_ovf_acc;
    w_report      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          w_state_nxt = S_SETTLE;
          w_tmr_nxt   = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_tmr == '0) begin
          w_state_nxt   = S_MEASURE;
          w_tmr_nxt     = WINDOW_LD;
          w_cnt_nxt     = '0;
          w_ovf_acc_nxt = 1'b0;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      S_MEASURE: begin
        // A rise on the final window cycle is folded in before the latch.
        if (w_rise) begin
          if (r_cnt == CNT_MAX) w_ovf_acc_nxt = 1'b1;
          else                  w_cnt_nxt     = r_cnt + 1'b1;
        end
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_tmr == '0) begin
          w_state_nxt = S_REPORT;
          w_report    = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_cnt      <= '0;
      r_ovf_acc  <= 1'b0;
      r_osc_en   <= 1'b0;
      r_valid    <= 1'b0;
      r_edge_cnt <= '0;
      r_stuck    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ovf_acc <= w_ovf_acc_nxt;
      r_osc_en  <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_MEASURE);
      r_valid   <= w_report;
      if (w_report) begin
        r_edge_cnt <= w_cnt_nxt;
        r_stuck    <= ({1'b0, w_cnt_nxt} < MIN_CMP);
        r_ovf      <= w_ovf_acc_nxt;
      end
    end
  end

  assign o_osc_en     = r_osc_en;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.valid    = r_valid;
  assign bus.edge_cnt = r_edge_cnt;
  assign bus.stuck    = r_stuck;
  assign bus.ovf      = r_ovf;

`ifdef RO_MON_IDLE_CHECK_EN
  logic [1:0] r_guard;
  logic       r_idle_err;

  // Guard delays the check until the oscillator has had time to stop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_guard    <= 2'd0;
      r_idle_err <= 1'b0;
    end else begin
      if (r_osc_en)                                  r_guard <= 2'd0;
      else if ((r_state == S_IDLE) && (r_guard != 2'd3)) r_guard <= r_guard + 2'd1;
      if (w_start_acc)                      r_idle_err <= 1'b0;
      else if ((r_guard == 2'd3) && r_sync2) r_idle_err <= 1'b1;
    end
  end

  assign o_idle_err = r_idle_err;
`else
  assign o_idle_err = 1'b0;
`endif

endmodule

// File: tb/tb_ring_osc_monitor.sv
// Directed bench for ring_osc_monitor: default build plus a CNT_W=4 instance.
module tb_ring_osc_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic osc_a = 1'b0;
  logic osc_b = 1'b0;
  logic en_a, en_b, ierr_a, ierr_b;
  logic [2:0] ph_a = 3'd0;
  logic [1:0] ph_b = 2'd0;
  int mode_a = 0;  // 0 held low, 1 held high, 2 toggle every 4 clk while enabled

  ring_osc_monitor_if #(.CNT_W(9)) bus_a ();
  ring_osc_monitor_if #(.CNT_W(4)) bus_b ();

  ring_osc_monitor dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_osc_in(osc_a),
    .o_osc_en(en_a), .o_idle_err(ierr_a), .bus(bus_a.slave)
  );

  ring_osc_monitor #(.CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_osc_in(osc_b),
    .o_osc_en(en_b), .o_idle_err(ierr_b), .bus(bus_b.slave)
  );

  always @(posedge clk) begin
    if (mode_a == 0)      osc_a <= 1'b0;
    else if (mode_a == 1) osc_a <= 1'b1;
    else if (!en_a) begin osc_a <= 1'b0; ph_a <= 3'd0; end
    else if (ph_a == 3'd3) begin osc_a <= ~osc_a; ph_a <= 3'd0; end
    else ph_a <= ph_a + 3'd1;
  end

  always @(posedge clk) begin
    if (!en_b) begin osc_b <= 1'b0; ph_b <= 2'd0; end
    else if (ph_b == 2'd1) begin osc_b <= ~osc_b; ph_b <= 2'd0; end
    else ph_b <= ph_b + 2'd1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic start_a();
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_osc_en"},   int'(en_a), 0);
    check({tag, "_busy"},     int'(bus_a.busy), 0);
    check({tag, "_valid"},    int'(bus_a.valid), 0);
    check({tag, "_edge_cnt"}, int'(bus_a.edge_cnt), 0);
    check({tag, "_stuck"},    int'(bus_a.stuck), 0);
    check({tag, "_ovf"},      int'(bus_a.ovf), 0);
    check({tag, "_idle_err"}, int'(ierr_a), 0);
  endtask

  // Full measurement on dut_a; returns the reported count.
  task automatic run_a(input string tag, input int lo, input int hi,
                       input int exp_stuck, input int exp_ovf, output int cnt);
    int kv;
    kv = -1;
    start_a();
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, "_busy_c1"}, int'(bus_a.busy), 1);
        check({tag, "_en_c1"},   int'(en_a), 1);
      end
      if (bus_a.valid) begin kv = k; break; end
    end
    cnt = int'(bus_a.edge_cnt);
    check({tag, "_valid_cycle"}, kv, 273);
    check({tag, "_en_at_valid"}, int'(en_a), 0);
    check({tag, "_busy_at_valid"}, int'(bus_a.busy), 1);
    check({tag, "_cnt"}, (cnt >= lo && cnt <= hi) ? lo : cnt, lo);
    check({tag, "_stuck"}, int'(bus_a.stuck), exp_stuck);
    check({tag, "_ovf"},   int'(bus_a.ovf), exp_ovf);
    @(negedge clk);
    check({tag, "_valid_1cyc"}, int'(bus_a.valid), 0);
    check({tag, "_busy_after"}, int'(bus_a.busy), 0);
  endtask

  initial begin
    int cnt, prev, kv, seen, exp_ierr;
`ifdef RO_MON_IDLE_CHECK_EN
    exp_ierr = 1;
`else
    exp_ierr = 0;
`endif
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.start = 1'b0; bus_a.abort = 1'b0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check_reset_a("por");

    // Saturating counter on the narrow instance.
    @(negedge clk);
    bus_b.start = 1'b1;
    @(posedge clk);
    #1 bus_b.start = 1'b0;
    kv = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (bus_b.valid) begin kv = k; break; end
    end
    check("b_valid_cycle", kv, 273);
    check("b_cnt", int'(bus_b.edge_cnt), 15);
    check("b_ovf", int'(bus_b.ovf), 1);
    check("b_stuck", int'(bus_b.stuck), 0);
    check("b_idle_err", int'(ierr_b), 0);

    // Oscillator high while disabled.
    @(negedge clk);
    mode_a = 1;
    repeat (10) @(negedge clk);
    mode_a = 0;
    repeat (4) @(negedge clk);
    check("idle_err_set", int'(ierr_a), exp_ierr);
    mode_a = 2;
    start_a();
    @(negedge clk);
    check("idle_err_clr", int'(ierr_a), 0);
    bus_a.abort = 1'b1;
    @(posedge clk);
    #1 bus_a.abort = 1'b0;
    @(negedge clk);
    check("abort_settle_busy", int'(bus_a.busy), 0);

    mode_a = 0;
    run_a("held0", 0, 0, 1, 0, cnt);
    mode_a = 1;
    run_a("held1", 0, 0, 1, 0, cnt);
    mode_a = 2;
    run_a("norm", 31, 33, 0, 0, prev);

    // Abort on MEASURE cycle 100 (cycle 116 after start).
    start_a();
    repeat (116) @(negedge clk);
    check("abort_pre_busy", int'(bus_a.busy), 1);
    bus_a.abort = 1'b1;
    @(posedge clk);
    #1 bus_a.abort = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(bus_a.busy), 0);
    check("abort_en", int'(en_a), 0);
    check("abort_cnt_kept", int'(bus_a.edge_cnt), prev);
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus_a.valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    run_a("post_abort", 31, 33, 0, 0, cnt);

    // Reset during SETTLE, then during MEASURE.
    start_a();
    repeat (5) @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    check_reset_a("rst_settle");
    run_a("after_rst_s", 31, 33, 0, 0, cnt);

    start_a();
    repeat (60) @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    check_reset_a("rst_meas");
    run_a("after_rst_m", 31, 33, 0, 0, cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
